// File: rtl/ble_setup_types_pkg.sv
// Shared types for the BLE setup sequencer: FSM states, the expected
// acknowledgement string and the command terminator byte.
package ble_setup_types_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        COUNT    = 4'd1,
        SEND_CMD = 4'd2,
        WAIT_TX  = 4'd3,
        WAIT_ACK = 4'd4,
        CHECK    = 4'd5,
        NEXT     = 4'd6,
        DONE     = 4'd7,
        FAIL     = 4'd8
    } state_e;

    localparam logic [7:0] ACK_O   = 8'h4F;
    localparam logic [7:0] ACK_K   = 8'h4B;
    localparam logic [7:0] ACK_CR  = 8'h0D;
    localparam logic [7:0] ACK_LF  = 8'h0A;
    localparam logic [7:0] LF_BYTE = 8'h0A;

    // Expected reply byte at position idx of "OK\r\n".
    function automatic logic [7:0] ack_expected(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ACK_O;
            2'd1:    b = ACK_K;
            2'd2:    b = ACK_CR;
            2'd3:    b = ACK_LF;
            default: b = ACK_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ble_setup_sequencer.sv
// Replays the stored BLE configuration commands over UART TX and requires an
// "OK\r\n" reply, guarded by the external ack timer, after each command.
module ble_setup_sequencer
    import ble_setup_types_pkg::*;
#(
    parameter int CMD_WIDTH = 32,
    parameter int CMD_DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   setting_up,
    output logic [$clog2(CMD_WIDTH*CMD_DEPTH)-1:0] mem_addr,
    input  logic [7:0]                             mem_rdata,
    input  logic [23:0]                            ack_time_count,
    output logic                                   tmr_start,
    output logic [23:0]                            tmr_count,
    input  logic                                   tmr_done,
    input  logic                                   ack_ready,
    output logic                                   get_ack_byte,
    input  logic                                   ack_valid,
    input  logic [7:0]                             ack_byte,
    input  logic                                   tx_full,
    input  logic                                   tx_done,
    output logic                                   byte_ready,
    output logic [7:0]                             cmd_byte,
    output logic [$clog2(CMD_DEPTH+1)-1:0]         cmd_number,
    output logic                                   fail,
    output logic                                   setup_done
);

    localparam int ADDR_W = $clog2(CMD_WIDTH * CMD_DEPTH);
    localparam int NUM_W  = $clog2(CMD_DEPTH + 1);
    localparam int SLOT_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int IDX_W  = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CMD_DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CMD_WIDTH - 1);
    localparam logic [NUM_W-1:0]  NUM_FULL  = NUM_W'(CMD_DEPTH);

    state_e            state_r, state_next_s;
    // phase_r: 0 = address just issued / settle cycle, 1 = data or status usable
    logic              phase_r, phase_next_s;
    logic [SLOT_W-1:0] slot_r, slot_next_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s;
    logic [1:0]        ack_idx_r, ack_idx_next_s;
    logic [NUM_W-1:0]  cmd_num_r, cmd_num_next_s;
    logic              wr_byte_s, pop_s, kick_s;

    logic [ADDR_W-1:0] mem_addr_r, mem_addr_next_s;
    logic              byte_ready_r, byte_ready_next_s;
    logic [7:0]        cmd_byte_r, cmd_byte_next_s;
    logic              get_ack_r, get_ack_next_s;
    logic              tmr_start_r, tmr_start_next_s;
    logic [23:0]       tmr_count_r, tmr_count_next_s;
    logic              fail_r, fail_next_s;
    logic              done_r, done_next_s;

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            phase_r      <= 1'b0;
            slot_r       <= {SLOT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            ack_idx_r    <= 2'd0;
            cmd_num_r    <= {NUM_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            byte_ready_r <= 1'b0;
            cmd_byte_r   <= 8'h00;
            get_ack_r    <= 1'b0;
            tmr_start_r  <= 1'b0;
            tmr_count_r  <= 24'h000000;
            fail_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            phase_r      <= phase_next_s;
            slot_r       <= slot_next_s;
            idx_r        <= idx_next_s;
            ack_idx_r    <= ack_idx_next_s;
            cmd_num_r    <= cmd_num_next_s;
            mem_addr_r   <= mem_addr_next_s;
            byte_ready_r <= byte_ready_next_s;
            cmd_byte_r   <= cmd_byte_next_s;
            get_ack_r    <= get_ack_next_s;
            tmr_start_r  <= tmr_start_next_s;
            tmr_count_r  <= tmr_count_next_s;
            fail_r       <= fail_next_s;
            done_r       <= done_next_s;
        end
    end

    // Next-state and counter logic; dropping setting_up wins over everything.
    always_comb begin
        state_next_s   = state_r;
        phase_next_s   = phase_r;
        slot_next_s    = slot_r;
        idx_next_s     = idx_r;
        ack_idx_next_s = ack_idx_r;
        cmd_num_next_s = cmd_num_r;
        wr_byte_s      = 1'b0;
        pop_s          = 1'b0;
        kick_s         = 1'b0;
        if (!setting_up) begin
            state_next_s   = IDLE;
            phase_next_s   = 1'b0;
            slot_next_s    = {SLOT_W{1'b0}};
            idx_next_s     = {IDX_W{1'b0}};
            ack_idx_next_s = 2'd0;
            cmd_num_next_s = {NUM_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s   = COUNT;
                    phase_next_s   = 1'b0;
                    slot_next_s    = {SLOT_W{1'b0}};
                    idx_next_s     = {IDX_W{1'b0}};
                    cmd_num_next_s = {NUM_W{1'b0}};
                end
                // The first empty slot index is the command count.
                COUNT: begin
                    if (!phase_r) begin
                        phase_next_s = 1'b1;
                    end else if (mem_rdata == 8'h00) begin
                        cmd_num_next_s = NUM_W'(slot_r);
                        slot_next_s    = {SLOT_W{1'b0}};
                        phase_next_s   = 1'b0;
                        state_next_s   = (slot_r == {SLOT_W{1'b0}}) ? DONE : SEND_CMD;
                    end else if (slot_r == SLOT_LAST) begin
                        cmd_num_next_s = NUM_FULL;
                        slot_next_s    = {SLOT_W{1'b0}};
                        phase_next_s   = 1'b0;
                        state_next_s   = SEND_CMD;
                    end else begin
                        slot_next_s  = slot_r + SLOT_W'(1);
                        phase_next_s = 1'b0;
                    end
                end
                SEND_CMD: begin
                    if (!phase_r) begin
                        phase_next_s = 1'b1;
                    end else if (!tx_full) begin
                        wr_byte_s    = 1'b1;
                        phase_next_s = 1'b0;
                        if ((mem_rdata == LF_BYTE) || (idx_r == IDX_LAST)) begin
                            idx_next_s   = {IDX_W{1'b0}};
                            state_next_s = WAIT_TX;
                        end else begin
                            idx_next_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        phase_next_s = 1'b1;
                    end
                end
                // First cycle skipped so tx_done reflects the byte just written.
                WAIT_TX: begin
                    if (!phase_r) begin
                        phase_next_s = 1'b1;
                    end else if (tx_done) begin
                        kick_s         = 1'b1;
                        ack_idx_next_s = 2'd0;
                        phase_next_s   = 1'b0;
                        state_next_s   = WAIT_ACK;
                    end else begin
                        phase_next_s = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_ready) begin
                        pop_s        = 1'b1;
                        state_next_s = CHECK;
                    end else if (tmr_done) begin
                        state_next_s = FAIL;
                    end else begin
                        state_next_s = WAIT_ACK;
                    end
                end
                CHECK: begin
                    if (ack_valid) begin
                        if (ack_byte != ack_expected(ack_idx_r)) begin
                            state_next_s = FAIL;
                        end else if (ack_idx_r == 2'd3) begin
                            state_next_s = NEXT;
                        end else begin
                            ack_idx_next_s = ack_idx_r + 2'd1;
                            kick_s         = 1'b1;
                            state_next_s   = WAIT_ACK;
                        end
                    end else if (tmr_done) begin
                        state_next_s = FAIL;
                    end else begin
                        state_next_s = CHECK;
                    end
                end
                NEXT: begin
                    if ((NUM_W'(slot_r) + NUM_W'(1)) == cmd_num_r) begin
                        state_next_s = DONE;
                    end else begin
                        slot_next_s  = slot_r + SLOT_W'(1);
                        idx_next_s   = {IDX_W{1'b0}};
                        phase_next_s = 1'b0;
                        state_next_s = SEND_CMD;
                    end
                end
                DONE:    state_next_s = DONE;
                FAIL:    state_next_s = FAIL;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        mem_addr_next_s   = ADDR_W'(slot_next_s) * ADDR_W'(CMD_WIDTH) + ADDR_W'(idx_next_s);
        byte_ready_next_s = wr_byte_s;
        get_ack_next_s    = pop_s;
        tmr_start_next_s  = kick_s;
        fail_next_s       = (state_next_s == FAIL);
        done_next_s       = (state_next_s == DONE);
        if (state_next_s == IDLE) begin
            cmd_byte_next_s  = 8'h00;
            tmr_count_next_s = 24'h000000;
        end else begin
            cmd_byte_next_s  = wr_byte_s ? mem_rdata : cmd_byte_r;
            tmr_count_next_s = ack_time_count;
        end
    end

    assign mem_addr     = mem_addr_r;
    assign byte_ready   = byte_ready_r;
    assign cmd_byte     = cmd_byte_r;
    assign get_ack_byte = get_ack_r;
    assign tmr_start    = tmr_start_r;
    assign tmr_count    = tmr_count_r;
    assign cmd_number   = cmd_num_r;
    assign fail         = fail_r;
    assign setup_done   = done_r;

endmodule

// File: tb/tb_ble_setup_sequencer.sv
// Bench for ble_setup_sequencer: behavioural command memory, UART TX/RX and
// ack timer models, with a byte scoreboard on the TX write path.
module tb_ble_setup_sequencer;

    localparam int CMD_WIDTH = 32;
    localparam int CMD_DEPTH = 16;
    localparam int TX_BYTE_CYC = 10;
    localparam logic [31:0] REPLY_OK = 32'h4F4B0D0A;
    localparam logic [31:0] REPLY_OX = 32'h4F580D0A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        setting_up = 1'b0;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [23:0] ack_time_count = 24'd500;
    logic        tmr_start;
    logic [23:0] tmr_count;
    logic        tmr_done = 1'b0;
    logic        ack_ready = 1'b0;
    logic        get_ack_byte;
    logic        ack_valid = 1'b0;
    logic [7:0]  ack_byte = 8'h00;
    logic        tx_full = 1'b0;
    logic        tx_done = 1'b1;
    logic        byte_ready;
    logic [7:0]  cmd_byte;
    logic [4:0]  cmd_number;
    logic        fail;
    logic        setup_done;

    logic [7:0]  mem [0:CMD_WIDTH*CMD_DEPTH-1];
    logic [7:0]  exp_q [$];
    logic [7:0]  tx_fifo [$];
    logic [7:0]  rx_q [$];
    logic [31:0] reply_word [0:3];
    logic [7:0]  mon_exp, mon_tx;
    logic [23:0] tmr_cnt;
    bit          tmr_run = 1'b0;
    bit          auto_reply = 1'b0;
    int          tx_busy = 0;
    int          lf_cnt = 0;
    int          wr_count = 0;
    int          total = 0;
    int          bad = 0;

    ble_setup_sequencer #(.CMD_WIDTH(CMD_WIDTH), .CMD_DEPTH(CMD_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .setting_up(setting_up),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ack_time_count(ack_time_count), .tmr_start(tmr_start), .tmr_count(tmr_count),
        .tmr_done(tmr_done), .ack_ready(ack_ready), .get_ack_byte(get_ack_byte),
        .ack_valid(ack_valid), .ack_byte(ack_byte), .tx_full(tx_full), .tx_done(tx_done),
        .byte_ready(byte_ready), .cmd_byte(cmd_byte), .cmd_number(cmd_number),
        .fail(fail), .setup_done(setup_done)
    );

    always #5 clk = ~clk;

    // Environment models and TX scoreboard, all updated on the rising edge.
    initial forever begin
        @(posedge clk);
        mem_rdata <= mem[mem_addr];
        if (byte_ready === 1'b1) begin
            wr_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_byte unexpected write got=%h want=none", cmd_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cmd_byte !== mon_exp) begin
                    bad++;
                    $display("FAIL tx_byte got=%h want=%h", cmd_byte, mon_exp);
                end
            end
            tx_fifo.push_back(cmd_byte);
        end
        if (tx_busy > 0) begin
            tx_busy--;
        end else if (tx_fifo.size() != 0) begin
            mon_tx = tx_fifo.pop_front();
            tx_busy = TX_BYTE_CYC;
            if (mon_tx == 8'h0A && auto_reply && lf_cnt < 4) begin
                rx_q.push_back(reply_word[lf_cnt][31:24]);
                rx_q.push_back(reply_word[lf_cnt][23:16]);
                rx_q.push_back(reply_word[lf_cnt][15:8]);
                rx_q.push_back(reply_word[lf_cnt][7:0]);
                lf_cnt++;
            end
        end
        tx_done <= (tx_fifo.size() == 0 && tx_busy == 0);
        ack_valid <= 1'b0;
        if (get_ack_byte === 1'b1 && rx_q.size() != 0) begin
            ack_byte  <= rx_q.pop_front();
            ack_valid <= 1'b1;
        end
        ack_ready <= (rx_q.size() != 0);
        tmr_done <= 1'b0;
        if (tmr_start === 1'b1) begin
            tmr_cnt = tmr_count;
            tmr_run = 1'b1;
        end else if (tmr_run) begin
            if (tmr_cnt <= 24'd1) begin
                tmr_done <= 1'b1;
                tmr_run = 1'b0;
            end else begin
                tmr_cnt = tmr_cnt - 24'd1;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < CMD_WIDTH*CMD_DEPTH; i++) mem[i] = 8'h00;
    endtask

    // Stores text + CR LF in a slot; optionally queues it as expected TX bytes.
    task automatic load_cmd(input int slot, input string s, input bit expect_tx);
        logic [7:0] b;
        for (int i = 0; i < s.len() + 2; i++) begin
            b = (i < s.len()) ? s[i] : ((i == s.len()) ? 8'h0D : 8'h0A);
            mem[slot*CMD_WIDTH + i] = b;
            if (expect_tx) exp_q.push_back(b);
        end
    endtask

    task automatic start_seq();
        int n;
        setting_up = 1'b0;
        @(negedge clk);
        n = 0;
        while ((tx_fifo.size() != 0 || tx_busy != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL tx_drain got=busy want=idle");
        end
        rx_q.delete();
        lf_cnt = 0;
        wr_count = 0;
        tmr_run = 1'b0;
        repeat (2) @(negedge clk);
        setting_up = 1'b1;
    endtask

    task automatic wait_end(input string name, input int limit);
        int n;
        n = 0;
        while (setup_done !== 1'b1 && fail !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s end_timeout got=%0d want<%0d", name, n, limit);
        end
    endtask

    task automatic wait_tmr_start(input string name);
        int n;
        n = 0;
        while (tmr_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 1000) begin
            bad++;
            $display("FAIL %s tmr_start_timeout got=%0d want<1000", name, n);
        end
    endtask

    task automatic test_reset();
        setting_up = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({byte_ready, get_ack_byte, tmr_start, fail, setup_done, cmd_byte, mem_addr, cmd_number} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {byte_ready, get_ack_byte, tmr_start, fail, setup_done, cmd_byte, mem_addr, cmd_number});
        end
        setting_up = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_three_cmds();
        clear_mem();
        load_cmd(0, "AT", 1'b1);
        load_cmd(1, "AT+ROLE0", 1'b1);
        load_cmd(2, "AT+NAMEX", 1'b1);
        for (int i = 0; i < 4; i++) reply_word[i] = REPLY_OK;
        auto_reply = 1'b1;
        ack_time_count = 24'd500;
        start_seq();
        wait_end("three_cmds", 3000);
        total += 5;
        if (setup_done !== 1'b1) begin bad++; $display("FAIL three_cmds setup_done got=%b want=1", setup_done); end
        if (fail !== 1'b0) begin bad++; $display("FAIL three_cmds fail got=%b want=0", fail); end
        if (cmd_number !== 5'd3) begin bad++; $display("FAIL three_cmds cmd_number got=%0d want=3", cmd_number); end
        if (wr_count != 24) begin bad++; $display("FAIL three_cmds writes got=%0d want=24", wr_count); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL three_cmds pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_bad_reply();
        clear_mem();
        load_cmd(0, "AT", 1'b1);
        load_cmd(1, "AT+ROLE0", 1'b1);
        load_cmd(2, "AT+NAMEX", 1'b0);
        reply_word[1] = REPLY_OX;
        auto_reply = 1'b1;
        start_seq();
        wait_end("bad_reply", 3000);
        total += 3;
        if (fail !== 1'b1) begin bad++; $display("FAIL bad_reply fail got=%b want=1", fail); end
        if (setup_done !== 1'b0) begin bad++; $display("FAIL bad_reply setup_done got=%b want=0", setup_done); end
        if (rx_q.size() != 2) begin bad++; $display("FAIL bad_reply rx_left got=%0d want=2", rx_q.size()); end
        repeat (300) @(negedge clk);
        total += 2;
        if (wr_count != 14) begin bad++; $display("FAIL bad_reply writes got=%0d want=14", wr_count); end
        if (fail !== 1'b1) begin bad++; $display("FAIL bad_reply fail_hold got=%b want=1", fail); end
        reply_word[1] = REPLY_OK;
    endtask

    task automatic test_timeout();
        int n;
        clear_mem();
        load_cmd(0, "AT", 1'b1);
        auto_reply = 1'b0;
        ack_time_count = 24'd3125;
        start_seq();
        wait_tmr_start("timeout");
        total++;
        if (tmr_count !== 24'd3125) begin bad++; $display("FAIL timeout tmr_count got=%0d want=3125", tmr_count); end
        n = 0;
        while (fail !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total += 2;
        if (fail !== 1'b1) begin bad++; $display("FAIL timeout fail got=%b want=1", fail); end
        if (n < 3120 || n > 3135) begin bad++; $display("FAIL timeout latency got=%0d want=3120..3135", n); end
    endtask

    task automatic test_spaced_reply();
        clear_mem();
        load_cmd(0, "AT", 1'b1);
        auto_reply = 1'b0;
        ack_time_count = 24'd3000;
        start_seq();
        wait_tmr_start("spaced");
        for (int i = 0; i < 4; i++) begin
            repeat (1000) @(negedge clk);
            rx_q.push_back(REPLY_OK[31-8*i -: 8]);
        end
        wait_end("spaced", 200);
        total += 2;
        if (setup_done !== 1'b1) begin bad++; $display("FAIL spaced setup_done got=%b want=1", setup_done); end
        if (fail !== 1'b0) begin bad++; $display("FAIL spaced fail got=%b want=0", fail); end
    endtask

    task automatic test_empty_slot0();
        int n;
        clear_mem();
        start_seq();
        n = 0;
        while (setup_done !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (setup_done !== 1'b1) begin bad++; $display("FAIL empty setup_done got=%b want=1 after=%0d", setup_done, n); end
        repeat (20) @(negedge clk);
        total += 2;
        if (wr_count != 0) begin bad++; $display("FAIL empty writes got=%0d want=0", wr_count); end
        if (cmd_number !== 5'd0) begin bad++; $display("FAIL empty cmd_number got=%0d want=0", cmd_number); end
    endtask

    task automatic test_tx_full();
        int n, snap;
        clear_mem();
        load_cmd(0, "AT+ROLE0", 1'b1);
        auto_reply = 1'b1;
        ack_time_count = 24'd500;
        start_seq();
        n = 0;
        while (wr_count < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_full = 1'b1;
        repeat (2) @(negedge clk);
        snap = wr_count;
        repeat (100) @(negedge clk);
        total++;
        if (wr_count != snap) begin bad++; $display("FAIL tx_full stalled_writes got=%0d want=%0d", wr_count, snap); end
        tx_full = 1'b0;
        wait_end("tx_full", 1000);
        total += 3;
        if (setup_done !== 1'b1) begin bad++; $display("FAIL tx_full setup_done got=%b want=1", setup_done); end
        if (wr_count != 10) begin bad++; $display("FAIL tx_full writes got=%0d want=10", wr_count); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL tx_full pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int n, snap;
        clear_mem();
        load_cmd(0, "AT+NAMEX", 1'b1);
        auto_reply = 1'b0;
        start_seq();
        n = 0;
        while (wr_count < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        setting_up = 1'b0;
        @(negedge clk);
        snap = wr_count;
        total += 2;
        if ({byte_ready, get_ack_byte, tmr_start, fail, setup_done, cmd_byte, mem_addr, cmd_number} !== 27'd0) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=0", {byte_ready, get_ack_byte, tmr_start, fail, setup_done, cmd_byte, mem_addr, cmd_number});
        end
        if (tmr_count !== 24'd0) begin bad++; $display("FAIL abort_tmr_count got=%0d want=0", tmr_count); end
        repeat (10) @(negedge clk);
        total++;
        if (wr_count != snap || fail !== 1'b0) begin bad++; $display("FAIL abort_quiet got=%0d/%b want=%0d/0", wr_count, fail, snap); end
        exp_q.delete();
    endtask

    task automatic test_width_limit();
        clear_mem();
        for (int i = 0; i < CMD_WIDTH; i++) begin
            mem[i] = 8'h41;
            exp_q.push_back(8'h41);
        end
        mem[CMD_WIDTH] = 8'h00;
        auto_reply = 1'b0;
        start_seq();
        for (int i = 0; i < 4; i++) rx_q.push_back(REPLY_OK[31-8*i -: 8]);
        wait_end("width", 2000);
        total += 4;
        if (setup_done !== 1'b1) begin bad++; $display("FAIL width setup_done got=%b want=1", setup_done); end
        if (wr_count != CMD_WIDTH) begin bad++; $display("FAIL width writes got=%0d want=%0d", wr_count, CMD_WIDTH); end
        if (cmd_number !== 5'd1) begin bad++; $display("FAIL width cmd_number got=%0d want=1", cmd_number); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL width pending got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        clear_mem();
        for (int i = 0; i < 4; i++) reply_word[i] = REPLY_OK;
        test_reset();
        test_three_cmds();
        test_bad_reply();
        test_timeout();
        test_spaced_reply();
        test_empty_slot0();
        test_tx_full();
        test_abort();
        test_width_limit();
        setting_up = 1'b0;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
